// File: rtl/nco_meas_pkg.sv
// nco_meas_pkg: shared state type and default
// widths for the NCO frequency meter.
package nco_meas_pkg;

  localparam int DATA_W_DEF = 13;
  localparam int HYST_DEF   = 64;
  localparam int NPER_DEF   = 4;
  localparam int CNT_W_DEF  = 24;

  typedef enum logic {
    SEEK,
    COUNT
  } state_e;

endpackage

// File: rtl/nco_freq_meter_if.sv
// nco_freq_meter_if: sample stream in,
// measurement results out.
interface nco_freq_meter_if #(
  parameter int DATA_W = nco_meas_pkg::DATA_W_DEF,
  parameter int CNT_W  = nco_meas_pkg::CNT_W_DEF
);

  logic                     in_valid;
  logic signed [DATA_W-1:0] sin_i;
  logic [CNT_W-1:0]         meas_o;
  logic                     meas_valid;
  logic                     lock_o;
  logic                     ovf_o;

  modport master (
    output in_valid, sin_i,
    input  meas_o, meas_valid, lock_o, ovf_o
  );

  modport slave (
    input  in_valid, sin_i,
    output meas_o, meas_valid, lock_o, ovf_o
  );

endinterface

// File: rtl/nco_zc_detect.sv
// nco_zc_detect: rising zero crossing with
// hysteresis; evt is qualified by the accepted sample.
module nco_zc_detect
  import nco_meas_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int HYST   = HYST_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     acc,
  input  logic                     clear_i,
  input  logic signed [DATA_W-1:0] sin_i,
  output logic                     evt
);

  localparam logic signed [DATA_W-1:0] POS =
    DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] NEG = -POS;

  logic armed;
  logic lo;
  logic hi;

  assign lo  = sin_i <= NEG;
  assign hi  = sin_i >= POS;
  assign evt = acc & armed & hi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed <= 1'b0;
    end else if (clear_i) begin
      armed <= 1'b0;
    end else if (acc & lo) begin
      armed <= 1'b1;
    end else if (evt) begin
      armed <= 1'b0;
    end
  end

endmodule

// File: rtl/nco_freq_meter.sv
// nco_freq_meter: counts accepted samples over
// NPER sine periods, with lock and overflow status.
module nco_freq_meter
  import nco_meas_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int HYST   = HYST_DEF,
  parameter int NPER   = NPER_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic             clk,
  input logic             reset_n,
  input logic             clken,
  input logic             clear_i,
  nco_freq_meter_if.slave s
);

  localparam int PW = (NPER > 1) ? $clog2(NPER) : 1;
  localparam logic [PW-1:0] LAST = PW'(NPER - 1);

  state_e           state;
  state_e           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] meas;
  logic [CNT_W-1:0] meas_n;
  logic [PW-1:0]    per_cnt;
  logic [PW-1:0]    per_n;
  logic             mv;
  logic             mv_n;
  logic             ovf;
  logic             ovf_n;
  logic             lock;
  logic             lock_n;
  logic             acc;
  logic             evt;
  logic             close;
  logic             cnt_max;

  assign acc     = clken & s.in_valid;
  assign cnt_max = &cnt;
  assign close   = evt & (per_cnt == LAST);

  nco_zc_detect #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_zc (
    .clk     (clk),
    .reset_n (reset_n),
    .acc     (acc),
    .clear_i (clear_i),
    .sin_i   (s.sin_i),
    .evt     (evt)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    per_n   = per_cnt;
    meas_n  = meas;
    lock_n  = lock;
    mv_n    = 1'b0;
    ovf_n   = 1'b0;
    if (clear_i) begin
      state_n = SEEK;
      cnt_n   = '0;
      per_n   = '0;
      lock_n  = 1'b0;
    end else if (acc) begin
      unique case (state)
        SEEK: begin
          cnt_n = '0;
          per_n = '0;
          if (evt) state_n = COUNT;
        end
        COUNT: begin
          // closing event also opens the next window
          unique case (1'b1)
            close: begin
              meas_n = cnt + 1'b1;
              mv_n   = 1'b1;
              lock_n = 1'b1;
              cnt_n  = '0;
              per_n  = '0;
            end
            (cnt_max && !close): begin
              ovf_n   = 1'b1;
              lock_n  = 1'b0;
              state_n = SEEK;
              cnt_n   = '0;
              per_n   = '0;
            end
            default: begin
              cnt_n = cnt + 1'b1;
              per_n = per_cnt + PW'(evt);
            end
          endcase
        end
        default: state_n = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= SEEK;
      cnt     <= '0;
      per_cnt <= '0;
      meas    <= '0;
      lock    <= 1'b0;
      mv      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      per_cnt <= per_n;
      meas    <= meas_n;
      lock    <= lock_n;
      mv      <= mv_n;
      ovf     <= ovf_n;
    end
  end

  assign s.meas_o     = meas;
  assign s.meas_valid = mv & clken;
  assign s.lock_o     = lock;
  assign s.ovf_o      = ovf & clken;

endmodule

// File: tb/tb_nco_freq_meter.sv
// tb_nco_freq_meter: vector table, scoreboard
// and directed sequences for the frequency meter.
module tb_nco_freq_meter;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  typedef struct {
    logic signed [12:0] sin;
    logic               mv;
    int                 meas;
    logic               lock;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic clken   = 1'b1;
  logic clear_i = 1'b0;

  int   chk       = 0;
  int   fail      = 0;
  int   cyc       = 0;
  int   n         = 0;
  int   first_evt = 27;
  int   nco_win   = 0;
  int   a_ovf     = 0;
  bit   nco_mode  = 1'b0;
  bit   mute_a    = 1'b0;
  exp_t exp_q[$];

  nco_freq_meter_if #(.DATA_W(13), .CNT_W(24)) a ();
  nco_freq_meter_if #(.DATA_W(13), .CNT_W(10)) b ();

  nco_freq_meter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .clear_i (clear_i),
    .s       (a)
  );

  nco_freq_meter #(.CNT_W(10)) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .clear_i (clear_i),
    .s       (b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input longint act,
                       input longint req);
    chk++;
    if (act != req) begin
      fail++;
      $display("FAIL %s: got %0d, want %0d",
               nm, act, req);
    end
  endtask

  function automatic logic signed [12:0] tri_wave(
    input int i);
    int p;
    p = i % 100;
    if (p < 50) return 13'(-1000 + 40 * p);
    return 13'(1000 - 40 * (p - 50));
  endfunction

  function automatic vec_t mk(input int s,
                              input logic mv,
                              input int meas,
                              input logic lock);
    vec_t v;
    v.sin  = 13'(s);
    v.mv   = mv;
    v.meas = meas;
    v.lock = lock;
    return v;
  endfunction

  // main-DUT scoreboard: every pulse must match a queued entry
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (a.ovf_o) begin
        a_ovf++;
        check("main_ovf", a.ovf_o, 0);
      end
      if (a.meas_valid) begin
        if (nco_mode) begin
          nco_win++;
          if (nco_win > 1) begin
            chk++;
            if (a.meas_o < 1999 || a.meas_o > 2001) begin
              fail++;
              $display("FAIL nco_meas: got %0d, want 1999..2001",
                       a.meas_o);
            end
          end
        end else if (exp_q.size() == 0) begin
          chk++;
          fail++;
          $display("FAIL stray_pulse: meas_valid at cycle %0d meas %0d, want none",
                   cyc, a.meas_o);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cyc", cyc, e.cyc);
          check("pulse_meas", a.meas_o, e.val);
          check("pulse_lock", a.lock_o, 1);
        end
      end
    end
  end

  task automatic step(input logic v,
                      input logic signed [12:0] s);
    a.in_valid = v & ~mute_a;
    a.sin_i    = s;
    b.in_valid = v;
    b.sin_i    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int cnt,
                      input bit alt,
                      input int clr_at);
    bit last_push;
    last_push = 1'b0;
    for (int k = 0; k < cnt; k++) begin
      clear_i = 1'b0;
      if (alt) begin
        clken = !(k[0] && !last_push);
        step(!clken, 13'($urandom_range(0, 8191)));
        clken = 1'b1;
      end
      last_push = 1'b0;
      if (n == clr_at) begin
        clear_i   = 1'b1;
        first_evt = n + 100;
      end else if (n > first_evt &&
                   (n - first_evt) % 400 == 0) begin
        exp_q.push_back('{cyc + 1, 400});
        last_push = 1'b1;
      end
      step(1'b1, tri_wave(n));
      n++;
    end
    clear_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    step(1'b0, 13'sd0);
    step(1'b0, 13'sd0);
    check(nm, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_meas", a.meas_o, 0);
    check("rst_mv", a.meas_valid, 0);
    check("rst_lock", a.lock_o, 0);
    check("rst_ovf", a.ovf_o, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    n         = 0;
    first_evt = 27;
    exp_q.delete();
  endtask

  initial begin
    vec_t        tv[16];
    logic [31:0] ph;
    int          sv;
    int          stray;

    a.in_valid = 1'b0;
    a.sin_i    = '0;
    b.in_valid = 1'b0;
    b.sin_i    = '0;

    tv[0]  = mk(-64, 0, 0, 0);
    tv[1]  = mk(64, 0, 0, 0);
    tv[2]  = mk(-63, 0, 0, 0);
    tv[3]  = mk(64, 0, 0, 0);
    tv[4]  = mk(-64, 0, 0, 0);
    tv[5]  = mk(63, 0, 0, 0);
    tv[6]  = mk(64, 0, 0, 0);
    tv[7]  = mk(-65, 0, 0, 0);
    tv[8]  = mk(100, 0, 0, 0);
    tv[9]  = mk(-64, 0, 0, 0);
    tv[10] = mk(-100, 0, 0, 0);
    tv[11] = mk(0, 0, 0, 0);
    tv[12] = mk(64, 0, 0, 0);
    tv[13] = mk(-64, 0, 0, 0);
    tv[14] = mk(64, 1, 13, 1);
    tv[15] = mk(0, 0, 0, 1);

    do_reset();

    foreach (tv[i]) begin
      if (tv[i].mv) exp_q.push_back('{cyc + 1, tv[i].meas});
      step(1'b1, tv[i].sin);
      check($sformatf("vec%0d_mv", i), a.meas_valid, tv[i].mv);
      check($sformatf("vec%0d_lock", i), a.lock_o, tv[i].lock);
    end
    drain("vec_drain");

    do_reset();
    repeat (5000) begin
      sv = int'($urandom_range(0, 80)) - 40;
      step(1'b1, 13'(sv));
    end
    check("noise_lock", a.lock_o, 0);

    feed(1228, 1'b0, -1);
    check("tri_lock", a.lock_o, 1);
    drain("tri_drain");

    feed(800, 1'b1, -1);
    drain("alt_drain");

    feed(250, 1'b0, -1);
    do_reset();
    feed(828, 1'b0, 827);
    check("clr_lock", a.lock_o, 0);
    feed(400, 1'b0, -1);
    check("clr_nolock", a.lock_o, 0);
    feed(200, 1'b0, -1);
    check("relock", a.lock_o, 1);
    drain("clr_drain");

    do_reset();
    nco_mode = 1'b1;
    ph = '0;
    repeat (7000) begin
      ph = ph + 32'h0083126F;
      sv = int'(4095.0 * $sin(6.283185307179586 *
                real'(ph) / 4294967296.0));
      step(1'b1, 13'(sv));
    end
    step(1'b0, 13'sd0);
    check("nco_windows", nco_win, 3);
    nco_mode = 1'b0;

    do_reset();
    mute_a = 1'b1;
    for (int i = 0; i <= 427; i++) step(1'b1, tri_wave(i));
    check("b_mv", b.meas_valid, 1);
    check("b_meas", b.meas_o, 400);
    check("b_lock", b.lock_o, 1);
    stray = 0;
    for (int k = 1; k < 1024; k++) begin
      step(1'b1, 13'sd0);
      stray += int'(b.ovf_o);
    end
    check("b_early_ovf", stray, 0);
    step(1'b1, 13'sd0);
    check("b_ovf", b.ovf_o, 1);
    check("b_ovf_lock", b.lock_o, 0);
    check("b_ovf_meas", b.meas_o, 400);
    step(1'b1, 13'sd0);
    check("b_ovf_pulse", b.ovf_o, 0);
    stray = 0;
    for (int i = 0; i <= 427; i++) begin
      step(1'b1, tri_wave(i));
      if (i < 427) stray += int'(b.meas_valid);
    end
    check("b_relock_stray", stray, 0);
    check("b_relock_mv", b.meas_valid, 1);
    check("b_relock_meas", b.meas_o, 400);
    mute_a = 1'b0;
    step(1'b0, 13'sd0);

    check("main_ovf_total", a_ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             chk, fail);
    $finish;
  end

endmodule

// File: doc/nco_freq_meter.md
Name: nco_freq_meter

Overview:
- Receive-side counterpart of the NCO sine generator.
- Consumes the NCO's 13-bit two's-complement sine stream (fsin_o / out_valid) and measures its period.
- Hysteresis rising-zero-crossing detection; counts accepted samples over NPER whole periods.
- Reports the count for closed-loop checking of phi_inc_i, plus lock and overflow status.

Parameters:
- DATA_W, 13: sample width, two's complement.
- HYST, 64: hysteresis threshold magnitude, in LSBs.
- NPER, 4: periods per measurement window, >= 1.
- CNT_W, 24: sample-counter and result width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clken  in  1  clock enable; when low, all state holds.
- clear_i  in  1  synchronous abort; returns to SEEK.
- in_valid  in  1  sample qualifier, driven from NCO out_valid.
- sin_i  in  DATA_W  sine sample, two's complement.
- meas_o  out  CNT_W  accepted-sample count over the last NPER periods.
- meas_valid  out  1  one-cycle pulse when meas_o updates.
- lock_o  out  1  high after the first completed window; low after overflow, clear or reset.
- ovf_o  out  1  one-cycle pulse when the counter saturates.

Behaviour:
- Reset (asynchronous, reset_n=0): meas_o=0, meas_valid=0, lock_o=0, ovf_o=0, state=SEEK, armed=0, cnt=0, per_cnt=0.
- Accepted sample: clken & in_valid. Nothing advances otherwise.
  - When clken=0, meas_valid and ovf_o are forced 0.
- Crossing detector:
  - armed<=1 when an accepted sample <= -HYST.
  - Event when armed=1 and the accepted sample >= +HYST; the event clears armed in the same cycle.
  - Samples strictly between -HYST and +HYST change nothing.
- State SEEK:
  - cnt=0, per_cnt=0.
  - On the first event, go to COUNT.
- State COUNT:
  - cnt increments on every accepted sample, including the event sample.
  - Each event increments per_cnt.
  - On the event where per_cnt reaches NPER: meas_o<=cnt+1, meas_valid=1, lock_o<=1, cnt<=0, per_cnt<=0; stay in COUNT.
  - Windows are back-to-back: the closing event also opens the next window.
  - An ideal period of P samples gives meas_o = P*NPER exactly.
- Overflow:
  - Trigger: in COUNT, cnt = 2^CNT_W-1 and the accepted sample is not a closing event.
  - Action: ovf_o=1 for one cycle, lock_o<=0, go to SEEK. meas_o holds its last value.
- Latency: meas_valid and ovf_o are registered and assert on the clock edge that captures the triggering sample.
- Simultaneous events:
  - clear_i=1 beats an event or overflow: no pulses, go to SEEK, armed<=0, lock_o<=0, meas_o held.
  - clear_i acts regardless of clken.
- Reset mid-window discards the partial count; measurement restarts from SEEK.
- Arithmetic: all comparisons are signed at DATA_W bits; cnt is unsigned and never wraps.

Decomposition:
- Package nco_meas_pkg:
  - state enum {SEEK, COUNT}.
  - Default DATA_W, HYST and CNT_W constants.
- Sub-module nco_zc_detect: owns armed and the signed hysteresis compares; outputs a single-cycle event qualified by the accepted sample.
- Top level nco_freq_meter: FSM, counters, output registers.

Test Plan:
- Continuous triangle input, period 100, amplitude ±1000, in_valid=1, NPER=4 -> first meas_valid 400 samples after the first crossing; meas_o=400 every 400 cycles; lock_o=1.
- Same triangle with in_valid alternating 1/0 -> meas_o=400; pulses every 800 clocks.
- Noise of ±40 around 0 (inside HYST) for 5000 cycles -> no event, no meas_valid, state stays SEEK. Then CNT_W=10 with triangle followed by constant 0 -> ovf_o pulse when cnt=1023; lock_o=0; back to SEEK.
- reset_n low for 3 cycles at sample 250 of a window -> all outputs 0 immediately; next meas_o=400 arrives 400 samples after the first post-reset crossing.
- clear_i asserted on the cycle of the 4th closing event -> no meas_valid; lock_o=0; re-locks after a full new window.
- Real NCO with phi_inc_i=32'h0083126F, clken=1 -> meas_o in 1999..2001 on every window after the first; no ovf_o.
